// File: rtl/sram_bus_arbiter.sv
// Two-master (fetch / data) arbiter and command sequencer in front of the SRAM controller.
// One command strobe per transaction, Hready completion tracking, watchdog and misalignment error.
module sram_bus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        Hclock,
    input  logic        Hreset,
    input  logic        if_req,
    input  logic [21:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic        mem_size,
    input  logic [21:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        mem_err,
    output logic        Hselect,
    output logic        ready,
    output logic        Hwrite,
    output logic        Hsize,
    output logic [21:0] Haddress,
    output logic [31:0] Hwritedata,
    input  logic [31:0] Hreaddata,
    input  logic        Hready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic       GNT_IF      = 1'b0;
    localparam logic       GNT_MEM     = 1'b1;
    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        err_q, err_d;
    logic [3:0]  wdog_q, wdog_d;
    logic        hwrite_q, hwrite_d;
    logic        hsize_q, hsize_d;
    logic [21:0] haddr_q, haddr_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        gnt;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        wdog_d       = wdog_q;
        hwrite_d     = hwrite_q;
        hsize_d      = hsize_q;
        haddr_d      = haddr_q;
        hwdata_d     = hwdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        gnt          = last_grant_q;

        case (state_q)
            IDLE: begin
                if (if_req || mem_req) begin
                    // On conflict the master not served last time wins
                    gnt          = (if_req && mem_req) ? ~last_grant_q : mem_req;
                    grant_d      = gnt;
                    last_grant_d = gnt;
                    err_d        = 1'b0;
                    if (gnt == GNT_MEM && mem_size && mem_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        if (gnt == GNT_MEM) begin
                            hwrite_d = mem_we;
                            hsize_d  = mem_size;
                            haddr_d  = mem_addr;
                            hwdata_d = mem_wdata;
                        end else begin
                            hwrite_d = 1'b0;
                            hsize_d  = 1'b1;
                            haddr_d  = if_addr;
                        end
                    end
                end
            end
            ISSUE: begin
                wdog_d  = 4'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (Hready) begin
                    if (grant_q == GNT_MEM) mem_rdata_d = Hreaddata;
                    else                    if_rdata_d  = Hreaddata;
                    state_d = DONE;
                end else begin
                    // Forced error completion after TIMEOUT stalled WAIT cycles
                    wdog_d = 4'(wdog_q + 4'd1);
                    if (wdog_d == TIMEOUT_CNT) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Hclock or negedge Hreset) begin
        if (!Hreset) begin
            state_q      <= IDLE;
            grant_q      <= GNT_IF;
            last_grant_q <= GNT_IF;
            err_q        <= 1'b0;
            wdog_q       <= 4'd0;
            hwrite_q     <= 1'b0;
            hsize_q      <= 1'b0;
            haddr_q      <= '0;
            hwdata_q     <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            wdog_q       <= wdog_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
            haddr_q      <= haddr_d;
            hwdata_q     <= hwdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign Hselect    = (state_q == ISSUE);
    assign ready      = (state_q == ISSUE);
    assign if_ack     = (state_q == DONE) && (grant_q == GNT_IF);
    assign mem_ack    = (state_q == DONE) && (grant_q == GNT_MEM);
    assign mem_err    = mem_ack && err_q;
    assign Hwrite     = hwrite_q;
    assign Hsize      = hsize_q;
    assign Haddress   = haddr_q;
    assign Hwritedata = hwdata_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: per-cycle vector table plus hand sequences
// for arbitration, misalignment, watchdog timeout and reset mid-transaction.
module tb_sram_bus_arbiter;

    logic        Hclock = 1'b0;
    logic        Hreset = 1'b0;
    logic        if_req = 1'b0;
    logic [21:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic        mem_size = 1'b0;
    logic [21:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;
    logic        Hselect;
    logic        ready;
    logic        Hwrite;
    logic        Hsize;
    logic [21:0] Haddress;
    logic [31:0] Hwritedata;
    logic [31:0] Hreaddata = '0;
    logic        Hready = 1'b0;

    sram_bus_arbiter #(.TIMEOUT(15)) dut (
        .Hclock(Hclock), .Hreset(Hreset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
        .Hselect(Hselect), .ready(ready), .Hwrite(Hwrite), .Hsize(Hsize),
        .Haddress(Haddress), .Hwritedata(Hwritedata),
        .Hreaddata(Hreaddata), .Hready(Hready)
    );

    always #5 Hclock = ~Hclock;

    // {Hselect, ready, if_ack, mem_ack, mem_err}
    localparam logic [4:0] C0   = 5'b00000;
    localparam logic [4:0] CISS = 5'b11000;
    localparam logic [4:0] CIFA = 5'b00100;
    localparam logic [4:0] CMA  = 5'b00010;
    localparam logic [4:0] CME  = 5'b00011;

    typedef struct {
        logic        ir;
        logic [21:0] ia;
        logic        mr, mw, ms;
        logic [21:0] ma;
        logic [31:0] wd;
        logic        hr;
        logic [31:0] hd;
        logic [4:0]  exp_ctl;
        logic        chk_bus;
        logic [21:0] exp_addr;
        logic        exp_w, exp_s;
        logic        chk_wd;
        logic [31:0] exp_wd;
        logic        chk_if;
        logic [31:0] exp_if;
        logic        chk_mem;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t tbl[64];
    int   ntbl = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic ir, input logic [21:0] ia, input logic mr, input logic mw,
                       input logic ms, input logic [21:0] ma, input logic [31:0] wd,
                       input logic hr, input logic [31:0] hd, input logic [4:0] ctl);
        vec_t v;
        v.ir = ir; v.ia = ia; v.mr = mr; v.mw = mw; v.ms = ms; v.ma = ma; v.wd = wd;
        v.hr = hr; v.hd = hd; v.exp_ctl = ctl;
        v.chk_bus = 1'b0; v.exp_addr = '0; v.exp_w = 1'b0; v.exp_s = 1'b0;
        v.chk_wd = 1'b0; v.exp_wd = '0;
        v.chk_if = 1'b0; v.exp_if = '0;
        v.chk_mem = 1'b0; v.exp_mem = '0;
        tbl[ntbl] = v;
        ntbl++;
    endtask

    task automatic bus(input logic [21:0] a, input logic w, input logic s);
        tbl[ntbl-1].chk_bus = 1'b1;
        tbl[ntbl-1].exp_addr = a;
        tbl[ntbl-1].exp_w = w;
        tbl[ntbl-1].exp_s = s;
    endtask

    task automatic wd(input logic [31:0] d);
        tbl[ntbl-1].chk_wd = 1'b1;
        tbl[ntbl-1].exp_wd = d;
    endtask

    task automatic ifd(input logic [31:0] d);
        tbl[ntbl-1].chk_if = 1'b1;
        tbl[ntbl-1].exp_if = d;
    endtask

    task automatic memd(input logic [31:0] d);
        tbl[ntbl-1].chk_mem = 1'b1;
        tbl[ntbl-1].exp_mem = d;
    endtask

    task automatic cyc();
        @(posedge Hclock);
        #1;
    endtask

    function automatic logic [31:0] ctl();
        return 32'({Hselect, ready, if_ack, mem_ack, mem_err});
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Fetch read 0x104 -> DEADBEEF; Hready high in IDLE must be ignored
        row(1'b1, 22'h104, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b1, 32'h0, C0);
        row(1'b1, 22'h104, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0, 32'h0, CISS); bus(22'h104, 1'b0, 1'b1);
        row(1'b1, 22'h104, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b1, 32'hDEADBEEF, C0); bus(22'h104, 1'b0, 1'b1);
        row(1'b1, 22'h104, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0, 32'h0, CIFA); ifd(32'hDEADBEEF);
        row(1'b0, 22'h0, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0, 32'h0, C0); ifd(32'hDEADBEEF);
        // Word write 0x10; Hready high in ISSUE and DONE must be ignored
        row(1'b0, 22'h0, 1'b1, 1'b1, 1'b1, 22'h10, 32'h12345678, 1'b0, 32'h0, C0);
        row(1'b0, 22'h0, 1'b1, 1'b1, 1'b1, 22'h10, 32'h12345678, 1'b1, 32'h0, CISS);
        bus(22'h10, 1'b1, 1'b1); wd(32'h12345678);
        row(1'b0, 22'h0, 1'b1, 1'b1, 1'b1, 22'h10, 32'h12345678, 1'b0, 32'h0, C0);
        bus(22'h10, 1'b1, 1'b1); wd(32'h12345678);
        row(1'b0, 22'h0, 1'b1, 1'b1, 1'b1, 22'h10, 32'h12345678, 1'b0, 32'h0, C0);
        bus(22'h10, 1'b1, 1'b1); wd(32'h12345678);
        row(1'b0, 22'h0, 1'b1, 1'b1, 1'b1, 22'h10, 32'h12345678, 1'b1, 32'h0, C0);
        bus(22'h10, 1'b1, 1'b1); wd(32'h12345678);
        row(1'b0, 22'h0, 1'b1, 1'b1, 1'b1, 22'h10, 32'h12345678, 1'b1, 32'h0, CMA);
        row(1'b0, 22'h0, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0, 32'h0, C0);
        // Byte write 0xA5 at 0x13, Hready first high at t+5
        row(1'b0, 22'h0, 1'b1, 1'b1, 1'b0, 22'h13, 32'hA5, 1'b0, 32'h0, C0);
        row(1'b0, 22'h0, 1'b1, 1'b1, 1'b0, 22'h13, 32'hA5, 1'b0, 32'h0, CISS);
        bus(22'h13, 1'b1, 1'b0); wd(32'hA5);
        row(1'b0, 22'h0, 1'b1, 1'b1, 1'b0, 22'h13, 32'hA5, 1'b0, 32'h0, C0); wd(32'hA5);
        row(1'b0, 22'h0, 1'b1, 1'b1, 1'b0, 22'h13, 32'hA5, 1'b0, 32'h0, C0); wd(32'hA5);
        row(1'b0, 22'h0, 1'b1, 1'b1, 1'b0, 22'h13, 32'hA5, 1'b0, 32'h0, C0); wd(32'hA5);
        row(1'b0, 22'h0, 1'b1, 1'b1, 1'b0, 22'h13, 32'hA5, 1'b1, 32'h0, C0);
        row(1'b0, 22'h0, 1'b1, 1'b1, 1'b0, 22'h13, 32'hA5, 1'b0, 32'h0, CMA);
        // Byte read back from 0x13, request changed on the edge ending the ack
        row(1'b0, 22'h0, 1'b1, 1'b0, 1'b0, 22'h13, 32'h0, 1'b0, 32'h0, C0);
        row(1'b0, 22'h0, 1'b1, 1'b0, 1'b0, 22'h13, 32'h0, 1'b0, 32'h0, CISS); bus(22'h13, 1'b0, 1'b0);
        row(1'b0, 22'h0, 1'b1, 1'b0, 1'b0, 22'h13, 32'h0, 1'b1, 32'hA5, C0);
        row(1'b0, 22'h0, 1'b1, 1'b0, 1'b0, 22'h13, 32'h0, 1'b0, 32'h0, CMA); memd(32'hA5);
        row(1'b0, 22'h0, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0, 32'h0, C0);
        memd(32'hA5); ifd(32'hDEADBEEF);

        // Reset state
        repeat (2) @(posedge Hclock);
        #1;
        check("reset_ctl", ctl(), 32'(C0));
        check("reset_haddr", 32'(Haddress), 32'h0);
        check("reset_hwdata", Hwritedata, 32'h0);
        check("reset_hw_hs", 32'({Hwrite, Hsize}), 32'h0);
        check("reset_rdata", if_rdata | mem_rdata, 32'h0);
        Hreset = 1'b1;

        // Both masters held: data wins first after reset, then alternation
        if_req = 1'b1; if_addr = 22'h200;
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 1'b1; mem_addr = 22'h40;
        Hready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic gm;
            gm = (i % 2 == 0);
            Hreaddata = 32'h1000 + 32'(i);
            cyc();
            check($sformatf("conf%0d_issue", i), ctl(), 32'(CISS));
            check($sformatf("conf%0d_addr", i), 32'(Haddress), gm ? 32'h40 : 32'h200);
            cyc();
            cyc();
            check($sformatf("conf%0d_ack", i), ctl(), gm ? 32'(CMA) : 32'(CIFA));
            check($sformatf("conf%0d_rdata", i), gm ? mem_rdata : if_rdata, 32'h1000 + 32'(i));
            cyc();
        end
        if_req = 1'b0; mem_req = 1'b0; Hready = 1'b0;

        // Per-cycle vector table
        for (int i = 0; i < ntbl; i++) begin
            check($sformatf("vec%0d_ctl", i), ctl(), 32'(tbl[i].exp_ctl));
            if (tbl[i].chk_bus)
                check($sformatf("vec%0d_bus", i), 32'({Haddress, Hwrite, Hsize}),
                      32'({tbl[i].exp_addr, tbl[i].exp_w, tbl[i].exp_s}));
            if (tbl[i].chk_wd)  check($sformatf("vec%0d_hwdata", i), Hwritedata, tbl[i].exp_wd);
            if (tbl[i].chk_if)  check($sformatf("vec%0d_if_rdata", i), if_rdata, tbl[i].exp_if);
            if (tbl[i].chk_mem) check($sformatf("vec%0d_mem_rdata", i), mem_rdata, tbl[i].exp_mem);
            if_req = tbl[i].ir; if_addr = tbl[i].ia;
            mem_req = tbl[i].mr; mem_we = tbl[i].mw; mem_size = tbl[i].ms;
            mem_addr = tbl[i].ma; mem_wdata = tbl[i].wd;
            Hready = tbl[i].hr; Hreaddata = tbl[i].hd;
            cyc();
        end

        // Misaligned word read: error ack one cycle later, no strobe
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 1'b1; mem_addr = 22'h2;
        cyc();
        check("misalign_ack", ctl(), 32'(CME));
        mem_req = 1'b0;
        cyc();
        check("misalign_idle", ctl(), 32'(C0));

        // Watchdog: 15 stalled WAIT cycles then error completion
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 1'b1; mem_addr = 22'h20;
        mem_wdata = 32'hCAFEF00D; Hready = 1'b0;
        cyc();
        check("wdog_issue", ctl(), 32'(CISS));
        for (int k = 0; k < 15; k++) begin
            cyc();
            check($sformatf("wdog_wait%0d", k), ctl(), 32'(C0));
        end
        cyc();
        check("wdog_err_ack", ctl(), 32'(CME));
        mem_req = 1'b0;
        cyc();
        check("wdog_idle", ctl(), 32'(C0));

        // Reset asserted during WAIT of a write
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 1'b1; mem_addr = 22'h30;
        mem_wdata = 32'h11112222;
        cyc();
        cyc();
        cyc();
        Hreset = 1'b0;
        #1;
        check("rst_mid_ctl", ctl(), 32'(C0));
        check("rst_mid_bus", 32'({Haddress, Hwrite, Hsize}), 32'h0);
        check("rst_mid_hwdata", Hwritedata, 32'h0);
        check("rst_mid_rdata", if_rdata | mem_rdata, 32'h0);
        mem_req = 1'b0;
        cyc();
        check("rst_hold_noack", ctl(), 32'(C0));
        Hreset = 1'b1;

        // Fresh fetch after reset release
        if_req = 1'b1; if_addr = 22'h300; Hready = 1'b1; Hreaddata = 32'h5A5A5A5A;
        cyc();
        check("post_rst_issue", ctl(), 32'(CISS));
        check("post_rst_bus", 32'({Haddress, Hwrite, Hsize}), 32'({22'h300, 1'b0, 1'b1}));
        cyc();
        cyc();
        check("post_rst_ack", ctl(), 32'(CIFA));
        check("post_rst_rdata", if_rdata, 32'h5A5A5A5A);
        if_req = 1'b0;
        cyc();
        check("post_rst_idle", ctl(), 32'(C0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
